catch_game_engine: RTL and testbench
====================================

// Module: catch_game_engine
// PURPOSE
//  Game-logic stage directly upstream of the VGA compositor / 7-segment / LED top level. Consumes PS/2 decoder
//  events and the debounced one-pulse start button. Owns the Init/Game/Win/Lose FSM, farmer lane, four falling
//  objects (bug, green, orange, yellow), collision, score, lives and countdown. Drives the x/y lane positions,
//  state and digits that the top level renders.
// PARAMETERS
//  LANES      8            screen columns, 80 px each; 2..8
//  ROWS       6            fall rows per object; row ROWS-1 = farmer row; 2..8
//  TICK_DIV   2**21        clk cycles per fall tick
//  SEC_DIV    100_000_000  clk cycles per countdown second
//  GAME_SECS  60           countdown start value; 1..99
//  WIN_SCORE  50           score that ends the game as Win; 1..99
//  MAX_LIVES  3            lives at game start; 1..7
// PORTS
//  clk          in   1  system clock (100 MHz)
//  rst          in   1  asynchronous, active-high reset
//  start        in   1  one-cycle pulse from debounce+onepulse
//  key_valid    in   1  decoder been_ready strobe, one cycle
//  key_code     in   9  decoder last_change
//  key_pressed  in   1  key_down[last_change]: 1 = make, 0 = break
//  state        out  2  0 Init, 1 Game, 2 Win, 3 Lose
//  farmer_x     out  3  farmer lane
//  obj_x        out  12 {yellow,orange,green,bug} lanes, 3 b each
//  obj_y        out  12 {yellow,orange,green,bug} rows, 3 b each
//  score        out  7  0..99, saturating
//  time_left    out  7  seconds remaining, 0..GAME_SECS
//  lives        out  3  lives remaining
// BEHAVIOUR
//  Reset values: state=Init, farmer_x=LANES/2, score=0, time_left=GAME_SECS, lives=MAX_LIVES.
//  Reset lanes: bug=1, green=3, orange=5, yellow=6 (each mod LANES). Reset rows: bug=0, green=1, orange=2, yellow=3 (each mod ROWS).
//  Reset clears both prescalers; LFSR=16'hACE1. rst mid-game returns every register to its reset value.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; steps every clk cycle in every state.
//  tick: 1-cycle pulse when the tick prescaler hits TICK_DIV-1; sec: same with SEC_DIV. Both counters run only in Game.
//  FSM:
//   Init: start -> Game; entering Game reloads all reset values except LFSR and state.
//   Game: start -> Init (abort). Otherwise, after the tick update, first match wins:
//    lives==0 -> Lose; score>=WIN_SCORE -> Win; time_left==0 -> Lose.
//   Win, Lose: frozen outputs; start -> Init.
//  Movement (Game only): key_valid & key_pressed & code 9'h01C (A) -> farmer_x-1; code 9'h023 (D) -> +1.
//  Moves are clamped at 0 and LANES-1. Breaks and other codes are ignored.
//  Tick (Game only), evaluated per object in parallel:
//   row<ROWS-1: row+1.
//   row==ROWS-1: resolve, then row=0 and lane=LFSR[2:0] mod LANES (all respawning objects share that cycle's value).
//  Resolution compares against farmer_x registered before any same-cycle move (move and tick in one cycle: collision uses old lane, move still applies).
//   Caught fruit: green +1, orange +2, yellow +3; same-tick catches sum, saturating at 99.
//   Caught bug: lives-1, floor 0. Missed objects: no effect.
//  sec in Game: time_left-1, floor 0. The state check happens on the cycle after score/lives/time_left change.
//  start has priority over every simultaneous event. Outputs are registered; 1 cycle latency from input to output.
// STRUCTURE
//  Package catch_game_pkg: state encodings ST_INIT..ST_LOSE, object indices OBJ_BUG..OBJ_YELLOW,
//   point constants PTS_GREEN/ORANGE/YELLOW, key codes KEY_A=9'h01C, KEY_D=9'h023, LFSR_SEED.
//  Sub-module game_lfsr (16-bit free-running LFSR, async reset to seed). Prescalers and FSM stay inline.
// TESTING  (TICK_DIV=4, SEC_DIV=32, GAME_SECS=5, WIN_SCORE=6, MAX_LIVES=2)
//  T1 reset, then start -> state=1 next cycle, farmer_x=4, score=0, lives=2, time_left=5, obj_y=bug0/grn1/org2/yel3.
//  T2 in Game, A make x5 -> farmer_x 3,2,1,0,0; D break -> no move; A make in Init -> farmer_x unchanged.
//  T3 force yellow row 5, lane 4, farmer 4, tick -> score=3, yellow row 0, lane=LFSR mod 8. Second catch -> score=6, state=2 one cycle later.
//  T4 bug row 5 in farmer lane, two ticks of resolution -> lives 1 then 0 -> state=3. Same tick as score reaching 6 -> Lose wins.
//  T5 no catches for 5*32 cycles -> time_left 5..0, state=3. start -> Init. start -> Game with all values reloaded.
//  T6 rst asserted mid-Game, async mid-cycle -> all outputs at reset values without a clk edge. start in Game -> Init.

Source files
------------

// File: rtl/catch_game_pkg.sv
// catch_game_pkg: shared encodings, constants and helpers for the catch game engine
package catch_game_pkg;
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_GAME = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_e;
  localparam int NUM_OBJ    = 4;
  localparam int OBJ_BUG    = 0;
  localparam int OBJ_GREEN  = 1;
  localparam int OBJ_ORANGE = 2;
  localparam int OBJ_YELLOW = 3;
  localparam logic [7:0] PTS_GREEN  = 8'd1;
  localparam logic [7:0] PTS_ORANGE = 8'd2;
  localparam logic [7:0] PTS_YELLOW = 8'd3;
  localparam logic [7:0] SCORE_MAX  = 8'd99;
  localparam logic [8:0] KEY_A = 9'h01C;
  localparam logic [8:0] KEY_D = 9'h023;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
  function automatic logic [7:0] obj_points(int idx);
    return idx == OBJ_GREEN  ? PTS_GREEN  :
           idx == OBJ_ORANGE ? PTS_ORANGE :
           idx == OBJ_YELLOW ? PTS_YELLOW : 8'd0;
  endfunction
endpackage

// File: rtl/game_lfsr.sv
// game_lfsr: free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) supplying respawn lanes
module game_lfsr
  import catch_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] rnd_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_next(lfsr_q);
  assign rnd_o = lfsr_q[2:0];
endmodule

// File: rtl/catch_game_engine.sv
// catch_game_engine: game FSM, farmer and falling-object motion, collision scoring, lives and countdown
module catch_game_engine
  import catch_game_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int ROWS      = 6,
  parameter int TICK_DIV  = 2**21,
  parameter int SEC_DIV   = 100_000_000,
  parameter int GAME_SECS = 60,
  parameter int WIN_SCORE = 50,
  parameter int MAX_LIVES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        key_valid,
  input  logic [8:0]  key_code,
  input  logic        key_pressed,
  output logic [1:0]  state,
  output logic [2:0]  farmer_x,
  output logic [11:0] obj_x,
  output logic [11:0] obj_y,
  output logic [6:0]  score,
  output logic [6:0]  time_left,
  output logic [2:0]  lives
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = SEC_DIV > 1 ? $clog2(SEC_DIV) : 1;
  localparam logic [2:0]  LAST_ROW   = 3'(ROWS - 1);
  localparam logic [2:0]  LAST_LANE  = 3'(LANES - 1);
  localparam logic [2:0]  FARMER_RST = 3'(LANES / 2);
  localparam logic [2:0]  LIVES_RST  = 3'(MAX_LIVES);
  localparam logic [6:0]  TIME_RST   = 7'(GAME_SECS);
  localparam logic [6:0]  WIN_PTS    = 7'(WIN_SCORE);
  localparam logic [11:0] X_RST = {3'(6 % LANES), 3'(5 % LANES), 3'(3 % LANES), 3'(1 % LANES)};
  localparam logic [11:0] Y_RST = {3'(3 % ROWS), 3'(2 % ROWS), 3'(1 % ROWS), 3'(0)};

  state_e          state_q, state_d;
  logic [2:0]      farmer_q, farmer_d, lives_q, lives_d, rnd, spawn;
  logic [3:0][2:0] x_q, x_d, y_q, y_d;
  logic [6:0]      score_q, score_d, time_q, time_d;
  logic [7:0]      gain, sum;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            in_game, tick, sec, done, load, run, hit_bug;

  game_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .rnd_o (rnd)
  );

  assign spawn   = 3'(int'(rnd) % LANES);
  assign in_game = state_q == ST_GAME;
  assign tick    = in_game && tcnt_q == TW'(TICK_DIV - 1);
  assign sec     = in_game && scnt_q == SW'(SEC_DIV - 1);
  assign done    = lives_q == 3'd0 || score_q >= WIN_PTS || time_q == 7'd0;
  assign load    = start && state_q == ST_INIT;
  // A game that has already met an end condition freezes while it moves to Win/Lose
  assign run     = !start && in_game && !done;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_INIT;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (start) state_d = state_q == ST_INIT ? ST_GAME : ST_INIT;
    else if (in_game && done) state_d = lives_q == 3'd0 ? ST_LOSE : score_q >= WIN_PTS ? ST_WIN : ST_LOSE;
  end

  always_comb begin
    tcnt_d   = load ? '0 : in_game ? (tick ? '0 : tcnt_q + 1'b1) : tcnt_q;
    scnt_d   = load ? '0 : in_game ? (sec ? '0 : scnt_q + 1'b1) : scnt_q;
    farmer_d = farmer_q;
    x_d      = x_q;
    y_d      = y_q;
    score_d  = score_q;
    time_d   = time_q;
    lives_d  = lives_q;
    gain     = '0;
    sum      = '0;
    hit_bug  = 1'b0;
    if (load) begin
      farmer_d = FARMER_RST;
      x_d      = X_RST;
      y_d      = Y_RST;
      score_d  = '0;
      time_d   = TIME_RST;
      lives_d  = LIVES_RST;
    end else if (run) begin
      // Collisions are judged against the farmer lane held before this cycle's move
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (tick && y_q[i] == LAST_ROW) begin
          gain    = gain + (x_q[i] == farmer_q ? obj_points(i) : 8'd0);
          hit_bug = hit_bug | (i == OBJ_BUG && x_q[i] == farmer_q);
          y_d[i]  = '0;
          x_d[i]  = spawn;
        end else if (tick) y_d[i] = y_q[i] + 1'b1;
      end
      sum     = {1'b0, score_q} + gain;
      score_d = sum > SCORE_MAX ? SCORE_MAX[6:0] : sum[6:0];
      lives_d = hit_bug && lives_q != 3'd0 ? lives_q - 1'b1 : lives_q;
      time_d  = sec && time_q != 7'd0 ? time_q - 1'b1 : time_q;
      if (key_valid && key_pressed && key_code == KEY_A && farmer_q != 3'd0) farmer_d = farmer_q - 1'b1;
      else if (key_valid && key_pressed && key_code == KEY_D && farmer_q != LAST_LANE) farmer_d = farmer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      farmer_q <= FARMER_RST;
      x_q      <= X_RST;
      y_q      <= Y_RST;
      score_q  <= '0;
      time_q   <= TIME_RST;
      lives_q  <= LIVES_RST;
      tcnt_q   <= '0;
      scnt_q   <= '0;
    end else begin
      farmer_q <= farmer_d;
      x_q      <= x_d;
      y_q      <= y_d;
      score_q  <= score_d;
      time_q   <= time_d;
      lives_q  <= lives_d;
      tcnt_q   <= tcnt_d;
      scnt_q   <= scnt_d;
    end
  end

  assign state     = state_q;
  assign farmer_x  = farmer_q;
  assign obj_x     = x_q;
  assign obj_y     = y_q;
  assign score     = score_q;
  assign time_left = time_q;
  assign lives     = lives_q;
endmodule

// File: tb/tb_catch_game_engine.sv
// tb_catch_game_engine: cycle-level reference model with scoreboard, vector table and steered game sequences
module tb_catch_game_engine;
  localparam int LANES = 8, ROWS = 6, TICK_DIV = 4, SEC_DIV = 32;
  localparam int GAME_SECS = 5, WIN_SCORE = 6, MAX_LIVES = 2;
  localparam logic [8:0] K_A = 9'h01C, K_D = 9'h023, K_X = 9'h01D;
  localparam logic [45:0] RST_PACK  = {2'd0, 3'd4, 12'hD59, 12'h688, 7'd0, 7'd5, 3'd2};
  localparam logic [45:0] GAME_PACK = {2'd1, 3'd4, 12'hD59, 12'h688, 7'd0, 7'd5, 3'd2};

  typedef struct {
    logic       st;
    logic       kv;
    logic [8:0] kc;
    logic       kp;
    int         farmer;
    int         state;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, key_valid = 1'b0, key_pressed = 1'b0;
  logic [8:0]  key_code = '0;
  logic [1:0]  state;
  logic [2:0]  farmer_x, lives;
  logic [11:0] obj_x, obj_y;
  logic [6:0]  score, time_left;
  logic [45:0] got;
  logic [45:0] exp_q[$];
  vec_t        tbl[12];
  int errors = 0, checks = 0;
  int m_state, m_farmer, m_score, m_time, m_lives, m_tcnt, m_scnt;
  int m_lane[4], m_row[4];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  catch_game_engine #(
    .LANES(LANES), .ROWS(ROWS), .TICK_DIV(TICK_DIV), .SEC_DIV(SEC_DIV),
    .GAME_SECS(GAME_SECS), .WIN_SCORE(WIN_SCORE), .MAX_LIVES(MAX_LIVES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_code(key_code),
    .key_pressed(key_pressed), .state(state), .farmer_x(farmer_x), .obj_x(obj_x),
    .obj_y(obj_y), .score(score), .time_left(time_left), .lives(lives)
  );

  assign got = {state, farmer_x, obj_x, obj_y, score, time_left, lives};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic m_load();
    m_farmer = LANES / 2;
    m_lane = '{1, 3, 5, 6};
    m_row = '{0, 1, 2, 3};
    m_score = 0;
    m_time = GAME_SECS;
    m_lives = MAX_LIVES;
    m_tcnt = 0;
    m_scnt = 0;
  endtask

  task automatic m_reset();
    m_state = 0;
    m_lfsr = 16'hACE1;
    m_load();
  endtask

  function automatic logic [45:0] m_pack();
    return {2'(m_state), 3'(m_farmer), 3'(m_lane[3]), 3'(m_lane[2]), 3'(m_lane[1]), 3'(m_lane[0]),
            3'(m_row[3]), 3'(m_row[2]), 3'(m_row[1]), 3'(m_row[0]), 7'(m_score), 7'(m_time), 3'(m_lives)};
  endfunction

  task automatic m_step(input logic st, input logic kv, input logic [8:0] kc, input logic kp);
    bit tick = m_state == 1 && m_tcnt == TICK_DIV - 1;
    bit sec = m_state == 1 && m_scnt == SEC_DIV - 1;
    int spawn = int'(m_lfsr[2:0]) % LANES;
    int pts[4] = '{0, 1, 2, 3};
    int gain = 0;
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    if (st) begin
      if (m_state == 0) begin
        m_load();
        m_state = 1;
      end else m_state = 0;
      return;
    end
    if (m_state != 1) return;
    m_tcnt = tick ? 0 : m_tcnt + 1;
    m_scnt = sec ? 0 : m_scnt + 1;
    if (m_lives == 0) begin m_state = 3; return; end
    if (m_score >= WIN_SCORE) begin m_state = 2; return; end
    if (m_time == 0) begin m_state = 3; return; end
    if (tick) begin
      for (int o = 0; o < 4; o++) begin
        if (m_row[o] == ROWS - 1) begin
          if (m_lane[o] == m_farmer) begin
            if (o == 0) m_lives = m_lives > 0 ? m_lives - 1 : 0;
            else gain += pts[o];
          end
          m_row[o] = 0;
          m_lane[o] = spawn;
        end else m_row[o]++;
      end
    end
    m_score = m_score + gain > 99 ? 99 : m_score + gain;
    if (sec && m_time > 0) m_time--;
    if (kv && kp && kc == K_A && m_farmer > 0) m_farmer--;
    else if (kv && kp && kc == K_D && m_farmer < LANES - 1) m_farmer++;
  endtask

  task automatic step(input logic st, input logic kv, input logic [8:0] kc, input logic kp);
    @(negedge clk);
    start = st;
    key_valid = kv;
    key_code = kc;
    key_pressed = kp;
    m_step(st, kv, kc, kp);
    exp_q.push_back(m_pack());
    @(posedge clk);
    #1;
    check("cycle_outputs", got, exp_q.pop_front());
    start = 1'b0;
    key_valid = 1'b0;
    key_pressed = 1'b0;
  endtask

  // Steers the farmer toward objects in 'want' and away from any other object about to resolve
  task automatic play(input logic [3:0] want, input int budget);
    int n = 0;
    while (m_state == 1 && n < budget) begin
      int tgt = m_farmer, best = -1, thr = -1, dir = 0;
      for (int o = 0; o < 4; o++) begin
        if (want[o] && m_row[o] > best) begin best = m_row[o]; tgt = m_lane[o]; end
        if (!want[o] && m_row[o] == ROWS - 1) thr = m_lane[o];
      end
      if (thr == m_farmer) dir = (tgt > m_farmer || m_farmer == 0) ? 1 : -1;
      else if (tgt != m_farmer && m_farmer + (tgt > m_farmer ? 1 : -1) != thr) dir = tgt > m_farmer ? 1 : -1;
      step(1'b0, dir != 0, dir > 0 ? K_D : K_A, 1'b1);
      n++;
    end
    checks++;
    if (m_state == 1) begin
      errors++;
      $display("FAIL play_budget: game still running after %0d cycles, expected an end state", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, K_A, 1'b1, 3, 1};
    tbl[1]  = '{1'b0, 1'b1, K_A, 1'b1, 2, 1};
    tbl[2]  = '{1'b0, 1'b1, K_A, 1'b1, 1, 1};
    tbl[3]  = '{1'b0, 1'b1, K_A, 1'b1, 0, 1};
    tbl[4]  = '{1'b0, 1'b1, K_A, 1'b1, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, K_D, 1'b0, 0, 1};
    tbl[6]  = '{1'b0, 1'b1, K_X, 1'b1, 0, 1};
    tbl[7]  = '{1'b0, 1'b1, K_D, 1'b1, 1, 1};
    tbl[8]  = '{1'b1, 1'b0, K_A, 1'b0, 1, 0};
    tbl[9]  = '{1'b0, 1'b1, K_A, 1'b1, 1, 0};
    tbl[10] = '{1'b0, 1'b0, K_A, 1'b1, 1, 0};
    tbl[11] = '{1'b1, 1'b0, K_A, 1'b0, 4, 1};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    check("reset_outputs", got, RST_PACK);
    step(1'b1, 1'b0, '0, 1'b0);
    check("t1_state", state, 1);
    check("t1_farmer", farmer_x, 4);
    check("t1_score", score, 0);
    check("t1_lives", lives, 2);
    check("t1_time", time_left, 5);
    check("t1_obj_y", obj_y, 12'h688);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].st, tbl[i].kv, tbl[i].kc, tbl[i].kp);
      check($sformatf("tbl%0d_farmer", i), farmer_x, tbl[i].farmer);
      check($sformatf("tbl%0d_state", i), state, tbl[i].state);
    end
    play(4'b1110, 100);
    check("t3_win_state", state, 2);
    check("t3_win_score", score, 6);
    repeat (3) step(1'b0, 1'b1, K_D, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    check("t3_abort_to_init", state, 0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("t4_reload", got, GAME_PACK);
    play(4'b0001, 150);
    check("t4_lose_state", state, 3);
    check("t4_lives", lives, 0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    play(4'b0000, 250);
    check("t5_timeout_state", state, 3);
    check("t5_time_left", time_left, 0);
    check("t5_lives", lives, 2);
    repeat (2) step(1'b0, 1'b1, K_A, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    check("t5_to_init", state, 0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("t5_reload", got, GAME_PACK);
    repeat (5) step(1'b0, 1'b1, K_D, 1'b1);
    check("t6_clamp_right", farmer_x, 7);
    #1 rst = 1'b1;
    #1 check("t6_async_reset", got, RST_PACK);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0);
    check("t6_game_after_reset", state, 1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("t6_abort_to_init", state, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
